// File: rtl/calc_pkg.sv
// Shared constants, key decoding and state encoding for the keypad calculator controller.
package calc_pkg;

    localparam int MAX_DIGITS = 6;
    localparam int CALC_LAT   = 2;
    localparam int DISP_MAX   = 999999;

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int LAT_W = $clog2(CALC_LAT + 1);
    localparam int MAG_W = 20;

    localparam logic [4:0] KEY_EQ  = 5'd15;
    localparam logic [4:0] KEY_CLR = 5'd16;
    localparam logic [4:0] KEY_NEG = 5'd17;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;

    localparam logic [31:0] GLYPH_PLUS  = 32'h0010_0000;
    localparam logic [31:0] GLYPH_MINUS = 32'h0020_0000;
    localparam logic [31:0] GLYPH_MUL   = 32'h0030_0000;
    localparam logic [31:0] GLYPH_DIV   = 32'h0040_0000;
    localparam logic [31:0] GLYPH_MOD   = 32'h0050_0000;
    localparam logic [31:0] GLYPH_ERR   = 32'h00EE_0000;
    localparam logic [31:0] GLYPH_HAPPY = 32'h00A0_0000;

    typedef enum logic [2:0] {
        ST_OP1,
        ST_OPR,
        ST_OP2,
        ST_CALC,
        ST_RES,
        ST_ERR
    } state_e;

    typedef enum logic [2:0] {
        KC_NONE,
        KC_DIGIT,
        KC_OPER,
        KC_EQ,
        KC_CLR,
        KC_NEG
    } key_class_e;

    function automatic key_class_e classify(input logic [4:0] code);
        key_class_e kc;
        kc = KC_NONE;
        if (code <= 5'd9)         kc = KC_DIGIT;
        else if (code <= 5'd14)   kc = KC_OPER;
        else if (code == KEY_EQ)  kc = KC_EQ;
        else if (code == KEY_CLR) kc = KC_CLR;
        else if (code == KEY_NEG) kc = KC_NEG;
        return kc;
    endfunction

    function automatic logic [31:0] glyph_of(input logic [2:0] op);
        logic [31:0] g;
        case (op)
            OP_ADD:  g = GLYPH_PLUS;
            OP_SUB:  g = GLYPH_MINUS;
            OP_MUL:  g = GLYPH_MUL;
            OP_DIV:  g = GLYPH_DIV;
            OP_MOD:  g = GLYPH_MOD;
            default: g = GLYPH_ERR;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/entry_accum.sv
// Decimal entry accumulator: unsigned magnitude, sign flag and digit count,
// presented as a signed 32-bit value.
module entry_accum
    import calc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        start_i,
    input  logic        digit_i,
    input  logic        toggle_i,
    input  logic [3:0]  digit_val_i,
    output logic [31:0] value_o
);

    logic [MAG_W-1:0] mag_q, mag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic [MAG_W-1:0] mag_app;
    logic [31:0]      mag_ext;
    logic             full;
    logic             digit_ok;

    // The minus sign takes one display position, so a negative entry is one digit shorter.
    assign full     = (cnt_q == CNT_W'(MAX_DIGITS));
    assign digit_ok = !full
                      && !(neg_q && cnt_q == CNT_W'(MAX_DIGITS - 1))
                      && !(mag_q == '0 && digit_val_i == 4'd0);
    assign mag_app  = mag_q * MAG_W'(10) + MAG_W'(digit_val_i);

    always_comb begin
        mag_d = mag_q;
        cnt_d = cnt_q;
        neg_d = neg_q;
        if (clr_i) begin
            mag_d = '0;
            cnt_d = '0;
            neg_d = 1'b0;
        end else if (start_i) begin
            mag_d = MAG_W'(digit_val_i);
            cnt_d = (digit_val_i != 4'd0) ? CNT_W'(1) : '0;
            neg_d = 1'b0;
        end else if (digit_i) begin
            if (digit_ok) begin
                mag_d = mag_app;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (toggle_i) begin
            if (mag_q != '0 && !full) neg_d = ~neg_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mag_q <= '0;
            cnt_q <= '0;
            neg_q <= 1'b0;
        end else begin
            mag_q <= mag_d;
            cnt_q <= cnt_d;
            neg_q <= neg_d;
        end
    end

    assign mag_ext = 32'(mag_q);
    assign value_o = neg_q ? (32'd0 - mag_ext) : mag_ext;

endmodule

// File: rtl/calc_sequencer.sv
// Keypad calculator control FSM: builds operands, launches the calculate unit and
// selects what the segment driver shows.
//   state | meaning
//   OP1   | entering operand1
//   OPR   | operator chosen, waiting for first digit of operand2
//   OP2   | entering operand2
//   CALC  | calculate running, keys dropped
//   RES   | result shown, result is operand1
//   ERR   | error glyph shown until clear or a digit
module calc_sequencer
    import calc_pkg::*;
(
    input  logic        sw_clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    input  logic [31:0] ans,
    output logic [31:0] operand1,
    output logic [31:0] operand2,
    output logic [2:0]  operator,
    output logic        calc_start,
    output logic        busy,
    output logic [31:0] fnd_serial
);

    state_e            state_q, state_d;
    logic [31:0]       op1_q, op1_d;
    logic [31:0]       op2_q, op2_d;
    logic [2:0]        opr_q, opr_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic [31:0]       fnd_q, fnd_d;
    logic              refresh_q, refresh_d;
    logic [LAT_W-1:0]  lat_q, lat_d;

    key_class_e        kc;
    logic [2:0]        key_op;
    logic signed [31:0] ans_s;
    logic              ans_bad;

    logic              acc_clr, acc_start, acc_digit, acc_toggle;
    logic [31:0]       acc_value;

    assign kc      = key_valid ? classify(key_code) : KC_NONE;
    assign key_op  = 3'(key_code - 5'd10);
    assign ans_s   = $signed(ans);
    assign ans_bad = (ans == GLYPH_ERR) || (ans_s > DISP_MAX) || (ans_s < -DISP_MAX);

    entry_accum u_entry (
        .clk_i       (sw_clk),
        .rst_i       (rst),
        .clr_i       (acc_clr),
        .start_i     (acc_start),
        .digit_i     (acc_digit),
        .toggle_i    (acc_toggle),
        .digit_val_i (key_code[3:0]),
        .value_o     (acc_value)
    );

    always_comb begin
        state_d    = state_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        opr_d      = opr_q;
        start_d    = 1'b0;
        busy_d     = busy_q;
        lat_d      = lat_q;
        refresh_d  = 1'b0;
        acc_clr    = 1'b0;
        acc_start  = 1'b0;
        acc_digit  = 1'b0;
        acc_toggle = 1'b0;
        // The entry register settles one edge after an edit, so the display follows it a cycle later.
        fnd_d      = refresh_q ? acc_value : fnd_q;

        if (kc == KC_CLR && state_q != ST_CALC) begin
            op1_d   = '0;
            op2_d   = '0;
            opr_d   = OP_ADD;
            fnd_d   = '0;
            acc_clr = 1'b1;
            state_d = ST_OP1;
        end else begin
            case (state_q)
                ST_OP1: begin
                    if (kc == KC_DIGIT) begin
                        acc_digit = 1'b1;
                        refresh_d = 1'b1;
                    end else if (kc == KC_NEG) begin
                        acc_toggle = 1'b1;
                        refresh_d  = 1'b1;
                    end else if (kc == KC_OPER) begin
                        op1_d   = acc_value;
                        opr_d   = key_op;
                        fnd_d   = glyph_of(key_op);
                        state_d = ST_OPR;
                    end
                end
                ST_OPR: begin
                    if (kc == KC_DIGIT) begin
                        acc_start = 1'b1;
                        refresh_d = 1'b1;
                        state_d   = ST_OP2;
                    end else if (kc == KC_OPER) begin
                        opr_d = key_op;
                        fnd_d = glyph_of(key_op);
                    end
                end
                ST_OP2: begin
                    if (kc == KC_DIGIT) begin
                        acc_digit = 1'b1;
                        refresh_d = 1'b1;
                    end else if (kc == KC_NEG) begin
                        acc_toggle = 1'b1;
                        refresh_d  = 1'b1;
                    end else if (kc == KC_EQ) begin
                        op2_d   = acc_value;
                        start_d = 1'b1;
                        busy_d  = 1'b1;
                        lat_d   = LAT_W'(CALC_LAT);
                        state_d = ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (lat_q == '0) begin
                        busy_d = 1'b0;
                        if (ans_bad) begin
                            fnd_d   = GLYPH_ERR;
                            state_d = ST_ERR;
                        end else begin
                            op1_d   = ans;
                            fnd_d   = ans;
                            state_d = ST_RES;
                        end
                    end else begin
                        lat_d = lat_q - LAT_W'(1);
                    end
                end
                ST_RES, ST_ERR: begin
                    if (kc == KC_OPER && state_q == ST_RES) begin
                        opr_d   = key_op;
                        fnd_d   = glyph_of(key_op);
                        state_d = ST_OPR;
                    end else if (kc == KC_DIGIT) begin
                        op1_d     = '0;
                        op2_d     = '0;
                        opr_d     = OP_ADD;
                        acc_start = 1'b1;
                        refresh_d = 1'b1;
                        state_d   = ST_OP1;
                    end
                end
                default: state_d = ST_OP1;
            endcase
        end
    end

    always_ff @(posedge sw_clk) begin
        if (rst) begin
            state_q   <= ST_OP1;
            op1_q     <= '0;
            op2_q     <= '0;
            opr_q     <= OP_ADD;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            fnd_q     <= GLYPH_HAPPY;
            refresh_q <= 1'b0;
            lat_q     <= '0;
        end else begin
            state_q   <= state_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            opr_q     <= opr_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            fnd_q     <= fnd_d;
            refresh_q <= refresh_d;
            lat_q     <= lat_d;
        end
    end

    assign operand1   = op1_q;
    assign operand2   = op2_q;
    assign operator   = opr_q;
    assign calc_start = start_q;
    assign busy       = busy_q;
    assign fnd_serial = fnd_q;

endmodule
